// File: rtl/rf_ctrl_pkg.sv
// Shared constants for the register-file write-port control slice.
// Widths, requester indices and the hard-wired zero register.
package rf_ctrl_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    localparam int REQ_WB  = 0;
    localparam int REQ_DBG = 1;

    localparam logic [ADDR_W-1:0] REG_ZERO = 3'b000;

    // One-hot select of a register slot in a NUM_REGS-wide vector.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] addr);
        return NUM_REGS'(1) << addr;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; grant is one-hot or zero and combinational.
// The requester granted most recently loses the next contention.
module rr_arbiter2
    import rf_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    localparam logic LAST_WB  = 1'b0;
    localparam logic LAST_DBG = 1'b1;

    logic last;

    // Reset gates the grant so nothing is accepted while held in reset.
    always_comb begin
        gnt = 2'b00;
        if (reset) begin
            if (req[REQ_WB] && (!req[REQ_DBG] || last == LAST_DBG)) begin
                gnt[REQ_WB] = 1'b1;
            end else if (req[REQ_DBG]) begin
                gnt[REQ_DBG] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last <= LAST_DBG;
        end else if (|gnt) begin
            last <= gnt[REQ_DBG] ? LAST_DBG : LAST_WB;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between core writeback and debug,
// registers the winning write and tracks pending destinations in a busy scoreboard.
module rf_write_arbiter
    import rf_ctrl_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    output logic                wb_ready,
    input  logic                dbg_valid,
    input  logic [ADDR_W-1:0]   dbg_addr,
    input  logic [DATA_W-1:0]   dbg_data,
    output logic                dbg_ready,
    input  logic                rsv_valid,
    input  logic [ADDR_W-1:0]   rsv_addr,
    input  logic [ADDR_W-1:0]   chk_addr1,
    input  logic [ADDR_W-1:0]   chk_addr2,
    output logic                hazard1,
    output logic                hazard2,
    output logic                rf_write,
    output logic [ADDR_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic [NUM_REGS-1:0] busy
);

    logic [1:0]          req;
    logic [1:0]          gnt;
    logic                acc;
    logic                acc_wr;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_data;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] busy_nxt;

    assign req = {dbg_valid, wb_valid};

    rr_arbiter2 u_arb (
        .clock (clock),
        .reset (reset),
        .req   (req),
        .gnt   (gnt)
    );

    assign wb_ready  = gnt[REQ_WB];
    assign dbg_ready = gnt[REQ_DBG];

    always_comb begin
        acc      = |gnt;
        acc_addr = gnt[REQ_WB] ? wb_addr : dbg_addr;
        acc_data = gnt[REQ_WB] ? wb_data : dbg_data;
        acc_wr   = acc && (acc_addr != REG_ZERO);
    end

    // Writes to register zero are accepted but never reach the register file.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rf_write <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_write <= acc_wr;
            if (acc_wr) begin
                rf_waddr <= acc_addr;
                rf_wdata <= acc_data;
            end
        end
    end

    // Only writeback retires a reservation; a same-cycle reserve overrides the clear.
    always_comb begin
        clr_mask = gnt[REQ_WB] ? reg_onehot(wb_addr) : '0;
        set_mask = (rsv_valid && rsv_addr != REG_ZERO) ? reg_onehot(rsv_addr) : '0;
        busy_nxt = ((busy & ~clr_mask) | set_mask) & ~reg_onehot(REG_ZERO);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign hazard1 = busy[chk_addr1];
    assign hazard2 = busy[chk_addr2];

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_rf_write_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        wb_valid = 1'b0;
    logic [2:0]  wb_addr = '0;
    logic [15:0] wb_data = '0;
    logic        wb_ready;
    logic        dbg_valid = 1'b0;
    logic [2:0]  dbg_addr = '0;
    logic [15:0] dbg_data = '0;
    logic        dbg_ready;
    logic        rsv_valid = 1'b0;
    logic [2:0]  rsv_addr = '0;
    logic [2:0]  chk_addr1 = '0;
    logic [2:0]  chk_addr2 = '0;
    logic        hazard1;
    logic        hazard2;
    logic        rf_write;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [7:0]  busy;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    rf_write_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_ready  (wb_ready),
        .dbg_valid (dbg_valid),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .dbg_ready (dbg_ready),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .chk_addr1 (chk_addr1),
        .chk_addr2 (chk_addr2),
        .hazard1   (hazard1),
        .hazard2   (hazard2),
        .rf_write  (rf_write),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: who wrote last, a busy flag per register, pending rf write.
    int         m_last = 1;
    bit         m_busy [8];
    bit         m_wr = 0;
    int         m_waddr = 0;
    int         m_wdata = 0;

    function automatic int model_grant();
        if (!reset) return -1;
        if (wb_valid && dbg_valid) return (m_last == 1) ? 0 : 1;
        if (wb_valid) return 0;
        if (dbg_valid) return 1;
        return -1;
    endfunction

    function automatic logic [7:0] model_busy_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        m_last  = 1;
        m_wr    = 0;
        m_waddr = 0;
        m_wdata = 0;
        for (int i = 0; i < 8; i++) m_busy[i] = 0;
    endtask

    always @(negedge reset) model_reset();

    always @(posedge clock) begin
        int who;
        if (!reset) begin
            model_reset();
        end else begin
            who  = model_grant();
            m_wr = 0;
            if (who == 0) begin
                if (wb_addr != 0) begin
                    m_wr = 1; m_waddr = wb_addr; m_wdata = wb_data;
                end
                m_busy[wb_addr] = 0;
            end else if (who == 1) begin
                if (dbg_addr != 0) begin
                    m_wr = 1; m_waddr = dbg_addr; m_wdata = dbg_data;
                end
            end
            if (who >= 0) m_last = who;
            if (rsv_valid && rsv_addr != 0) m_busy[rsv_addr] = 1;
            m_busy[0] = 0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        int who;
        who = model_grant();
        chk("wb_ready",  32'(wb_ready),  32'(who == 0));
        chk("dbg_ready", 32'(dbg_ready), 32'(who == 1));
        chk("rf_write",  32'(rf_write),  32'(m_wr));
        if (m_wr) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
            chk("rf_wdata", 32'(rf_wdata), 32'(m_wdata));
        end
        chk("busy",    32'(busy),    32'(model_busy_vec()));
        chk("hazard1", 32'(hazard1), 32'(m_busy[chk_addr1]));
        chk("hazard2", 32'(hazard2), 32'(m_busy[chk_addr2]));
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wb_valid  = 0;
        dbg_valid = 0;
        rsv_valid = 0;
    endtask

    initial begin
        repeat (3) step();
        reset = 1;

        // Mid-cycle reset clears registered outputs and reservations at once.
        rsv_valid = 1; rsv_addr = 5;
        step();
        rsv_valid = 0;
        wb_valid = 1; wb_addr = 6; wb_data = 16'h1234;
        step();
        #2 reset = 0;
        #1;
        chk("rst_rf_write", 32'(rf_write), 32'd0);
        chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_rf_wdata", 32'(rf_wdata), 32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_wb_ready", 32'(wb_ready), 32'd0);
        step();

        // First write after release.
        wb_valid = 1; wb_addr = 3; wb_data = 16'hABCD;
        reset = 1;
        #1;
        chk("first_wb_ready", 32'(wb_ready), 32'd1);
        step();
        idle();
        chk("first_rf_write", 32'(rf_write), 32'd1);
        chk("first_rf_waddr", 32'(rf_waddr), 32'd3);
        chk("first_rf_wdata", 32'(rf_wdata), 32'hABCD);
        step();
        chk("first_pulse_end", 32'(rf_write), 32'd0);

        // Contention from a fresh reset: WB first, then strict alternation.
        reset = 0;
        step();
        reset = 1;
        wb_valid = 1;  wb_addr = 1;  wb_data = 16'h1111;
        dbg_valid = 1; dbg_addr = 2; dbg_data = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_wb_ready", 32'(wb_ready), 32'((i % 2) == 0));
            step();
            chk("cont_rf_write", 32'(rf_write), 32'd1);
            chk("cont_rf_waddr", 32'(rf_waddr), (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        idle();
        step();

        // Register zero: accepted, dropped, never busy.
        wb_valid = 1; wb_addr = 0; wb_data = 16'hFFFF;
        rsv_valid = 1; rsv_addr = 0;
        #1;
        chk("r0_wb_ready", 32'(wb_ready), 32'd1);
        step();
        idle();
        chk("r0_rf_write", 32'(rf_write), 32'd0);
        chk("r0_busy",     32'(busy),     32'd0);

        // Scoreboard reserve, DBG write leaves it, WB write clears it.
        rsv_valid = 1; rsv_addr = 5;
        step();
        rsv_valid = 0;
        chk("sb_busy_set", 32'(busy), 32'h20);
        chk_addr1 = 5;
        #1;
        chk("sb_hazard1", 32'(hazard1), 32'd1);
        dbg_valid = 1; dbg_addr = 5; dbg_data = 16'h0D0D;
        step();
        dbg_valid = 0;
        chk("sb_dbg_write", 32'(rf_write), 32'd1);
        chk("sb_dbg_busy",  32'(busy),     32'h20);
        wb_valid = 1; wb_addr = 5; wb_data = 16'h0505;
        step();
        wb_valid = 0;
        chk("sb_wb_write",  32'(rf_write), 32'd1);
        chk("sb_wb_waddr",  32'(rf_waddr), 32'd5);
        chk("sb_wb_clear",  32'(busy),     32'h00);
        chk("sb_hz_clear",  32'(hazard1),  32'd0);

        // Reserve and clear of the same register in one cycle: reserve wins.
        rsv_valid = 1; rsv_addr = 4;
        wb_valid = 1;  wb_addr = 4; wb_data = 16'h4444;
        step();
        idle();
        chk("setwin_busy",  32'(busy),     32'h10);
        chk("setwin_write", 32'(rf_write), 32'd1);
        chk("setwin_waddr", 32'(rf_waddr), 32'd4);
        wb_valid = 1; wb_addr = 4;
        step();
        idle();
        chk("setwin_clear", 32'(busy), 32'h00);

        // Back-to-back writes to 1..7 after reserving them all.
        for (int a = 1; a < 8; a++) begin
            rsv_valid = 1; rsv_addr = 3'(a);
            step();
        end
        rsv_valid = 0;
        chk("b2b_all_busy", 32'(busy), 32'hFE);
        for (int a = 1; a < 8; a++) begin
            wb_valid = 1; wb_addr = 3'(a); wb_data = 16'(16'h0100 * a + a);
            #1;
            chk("b2b_ready", 32'(wb_ready), 32'd1);
            step();
            chk("b2b_write", 32'(rf_write), 32'd1);
            chk("b2b_waddr", 32'(rf_waddr), 32'(a));
            chk("b2b_wdata", 32'(rf_wdata), 32'(16'h0100 * a + a));
            chk("b2b_busy",  32'(busy),     32'(8'hFE & ~8'((2 << a) - 1)));
        end
        idle();
        step();

        // Randomized traffic, checked by the per-cycle model compare.
        for (int n = 0; n < 800; n++) begin
            reset     = ($urandom_range(0, 99) != 0);
            wb_valid  = ($urandom_range(0, 2) != 0);
            wb_addr   = 3'($urandom_range(0, 7));
            wb_data   = 16'($urandom);
            dbg_valid = ($urandom_range(0, 2) == 0);
            dbg_addr  = 3'($urandom_range(0, 7));
            dbg_data  = 16'($urandom);
            rsv_valid = ($urandom_range(0, 2) == 0);
            rsv_addr  = 3'($urandom_range(0, 7));
            chk_addr1 = 3'($urandom_range(0, 7));
            chk_addr2 = 3'($urandom_range(0, 7));
            step();
        end
        reset = 1;
        idle();
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
